fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand pair present.
REQ-006 The block SHALL have port in_ready, output, 1, pipeline can accept this cycle.
REQ-007 The block SHALL have port dina, input, W, operand A as {sign, exp, frac}.
REQ-008 The block SHALL have port dinb, input, W, operand B.
REQ-009 The block SHALL have port op, input, 1, 0 = A+B, 1 = A-B.
REQ-010 The block SHALL have port out_valid, output, 1, result present.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 The block SHALL have port result, output, W, rounded sum/difference.
REQ-013 The block SHALL have port flags, output, 4, {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-014 The block SHALL be a 4-stage pipeline: unpack/classify, align, add/subtract, normalise+round+pack; one valid bit per stage.
REQ-015 The block SHALL advance all stages when adv = !out_valid || out_ready; in_ready = adv; holding on !adv keeps every stage register unchanged.
REQ-016 The block SHALL accept an operand when in_valid && in_ready; the result appears with out_valid exactly 4 cycles later when adv stays high; throughput 1 per cycle.
REQ-017 The block SHALL hold result/flags/out_valid stable while out_valid && !out_ready; no result is dropped, duplicated or reordered.
REQ-018 The block SHALL treat exp==0 inputs as subnormal: hidden bit 0, effective exponent 1.
REQ-019 The block SHALL align the smaller-exponent significand right with guard, round and sticky bits; shift amounts > MAN_W+3 saturate, with all shifted-out ones OR-ed into sticky.
REQ-020 The block SHALL, on effective subtraction, subtract the smaller magnitude from the larger; result sign is that of the larger operand.
REQ-021 The block SHALL normalise by leading-zero count, limiting the left shift so exponent never drops below 1 (gradual underflow to subnormal).
REQ-022 The block SHALL round to nearest, ties to even; a rounding carry-out increments the exponent.
REQ-023 The block SHALL return +0 for an exact-zero result of non-zero operands; 0 +/- 0 gives -0 only when both effective signs are negative.
REQ-024 The block SHALL return signed infinity with overflow=1 and inexact=1 when the rounded exponent reaches all-ones.
REQ-025 The block SHALL set underflow=1 when the result is tiny (below minimum normal before rounding) and inexact.
REQ-026 The block SHALL set inexact=1 whenever any of guard, round or sticky is nonzero.
REQ-027 The block SHALL, for any NaN input, output canonical quiet NaN {0, all-ones, 1, zeros}; invalid=1 if either input is signalling (frac MSB 0).
REQ-028 The block SHALL, for inf - inf (effective), output canonical NaN with invalid=1; inf with finite gives that infinity with flags 0.

Reset
REQ-029 The block SHALL, while rst is high at a clock edge, clear all stage valid bits, result, flags and out_valid to 0, with in_ready = 1 from the first cycle after reset.
REQ-030 The block SHALL discard operands in flight when rst is asserted mid-operation; none emerge after release.

Verification
REQ-031 The bench SHALL check dina=0x3F800000, dinb=0x40000000, op=0 -> result 0x40400000 4 cycles later, flags 0000.
REQ-032 The bench SHALL check 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001, inexact=1.
REQ-033 The bench SHALL check 0x3F800000 - 0x3F800000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000; 0x00000001 + 0x00000001 -> 0x00000002, flags 0000.
REQ-034 The bench SHALL check 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 0101; 0x7F800000 - 0x7F800000 -> 0x7FC00000, flags 1000; 0x7F800001 + 1.0 -> 0x7FC00000, invalid=1.
REQ-035 The bench SHALL check 8 back-to-back inputs with out_ready low for 3 cycles mid-stream -> all 8 results in order, in_ready low during stall, outputs stable while held.
REQ-036 The bench SHALL check rst pulsed with 3 operands in flight -> out_valid stays 0 afterward; the next operand yields its correct result at latency 4.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined IEEE-754 style adder/subtractor with round-to-nearest-even.
// Stages: unpack/classify, align, add/subtract, normalise+round+pack.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dina,
  input  logic [EXP_W+MAN_W:0]   dinb,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned EW = EXP_W + 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: classify and order operands by magnitude
  logic             sa, sbe, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, a_big;
  logic [EXP_W-1:0] ea, eb, eea, eeb;
  logic [MAN_W-1:0] fa, fb;
  logic             spec_c;
  logic [W-1:0]     spec_res_c;
  logic [3:0]       spec_flags_c;

  always_comb begin
    sa  = dina[W-1];
    ea  = dina[W-2:MAN_W];
    fa  = dina[MAN_W-1:0];
    sbe = dinb[W-1] ^ op;
    eb  = dinb[W-2:MAN_W];
    fb  = dinb[MAN_W-1:0];
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    eea    = (ea == '0) ? EXP_W'(1) : ea;
    eeb    = (eb == '0) ? EXP_W'(1) : eb;
    a_big  = dina[W-2:0] >= dinb[W-2:0];
    spec_c       = 1'b0;
    spec_res_c   = '0;
    spec_flags_c = '0;
    if (a_nan || b_nan) begin
      spec_c       = 1'b1;
      spec_res_c   = QNAN;
      spec_flags_c = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sbe)) begin
      spec_c       = 1'b1;
      spec_res_c   = QNAN;
      spec_flags_c = 4'b1000;
    end else if (a_inf) begin
      spec_c     = 1'b1;
      spec_res_c = dina;
    end else if (b_inf) begin
      spec_c     = 1'b1;
      spec_res_c = {sbe, eb, fb};
    end
  end

  logic             s1_valid, s1_spec, s1_sign, s1_zsign, s1_sub;
  logic [W-1:0]     s1_spec_res;
  logic [3:0]       s1_spec_flags;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0]   s1_sig_l, s1_sig_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid      <= in_valid;
      s1_spec       <= spec_c;
      s1_spec_res   <= spec_res_c;
      s1_spec_flags <= spec_flags_c;
      s1_sign       <= a_big ? sa : sbe;
      s1_zsign      <= sa & sbe;
      s1_sub        <= sa ^ sbe;
      s1_exp        <= a_big ? eea : eeb;
      s1_diff       <= a_big ? (eea - eeb) : (eeb - eea);
      s1_sig_l      <= a_big ? {|ea, fa} : {|eb, fb};
      s1_sig_s      <= a_big ? {|eb, fb} : {|ea, fa};
    end
  end

  // Stage 2: align the smaller significand, folding shifted-out bits into sticky
  logic [SW-1:0] ext_s, small_c;

  always_comb begin
    ext_s = {s1_sig_s, 3'b000};
    if (s1_diff >= EXP_W'(SW)) begin
      small_c    = '0;
      small_c[0] = |s1_sig_s;
    end else begin
      small_c    = ext_s >> s1_diff;
      small_c[0] = small_c[0] | (|(ext_s & ~({SW{1'b1}} << s1_diff)));
    end
  end

  logic             s2_valid, s2_spec, s2_sign, s2_zsign, s2_sub;
  logic [W-1:0]     s2_spec_res;
  logic [3:0]       s2_spec_flags;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_big, s2_small;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid      <= s1_valid;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
      s2_sign       <= s1_sign;
      s2_zsign      <= s1_zsign;
      s2_sub        <= s1_sub;
      s2_exp        <= s1_exp;
      s2_big        <= {s1_sig_l, 3'b000};
      s2_small      <= small_c;
    end
  end

  // Stage 3: magnitude add/subtract (big >= small, so never negative)
  logic             s3_valid, s3_spec, s3_sign, s3_zsign;
  logic [W-1:0]     s3_spec_res;
  logic [3:0]       s3_spec_flags;
  logic [EXP_W-1:0] s3_exp;
  logic [SW:0]      s3_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
    end else if (adv) begin
      s3_valid      <= s2_valid;
      s3_spec       <= s2_spec;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;
      s3_sign       <= s2_sign;
      s3_zsign      <= s2_zsign;
      s3_exp        <= s2_exp;
      s3_sum        <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                              : ({1'b0, s2_big} + {1'b0, s2_small});
    end
  end

  // Stage 4: normalise (left shift capped so exponent stays >= 1), round, pack
  logic [SW-1:0]    norm;
  logic [EW-1:0]    lz, sh, exp_m1, exp_n, exp_pre, exp_out;
  logic [MAN_W+1:0] mant_r;
  logic             found, tiny, inexact, rnd_up;
  logic [W-1:0]     res_c;
  logic [3:0]       flags_c;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (s3_sum[i]) found = 1'b1;
        else           lz    = lz + EW'(1);
      end
    end
    exp_m1 = {1'b0, s3_exp} - EW'(1);
    sh     = (lz < exp_m1) ? lz : exp_m1;
    if (s3_sum[SW]) begin
      norm    = s3_sum[SW:1];
      norm[0] = s3_sum[1] | s3_sum[0];
      exp_n   = {1'b0, s3_exp} + EW'(1);
    end else begin
      norm  = s3_sum[SW-1:0] << sh;
      exp_n = {1'b0, s3_exp} - sh;
    end
    tiny    = !norm[SW-1];
    exp_pre = tiny ? '0 : exp_n;
    inexact = |norm[2:0];
    rnd_up  = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r  = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    exp_out = exp_pre + EW'(mant_r[MAN_W+1]) + EW'(tiny & mant_r[MAN_W]);
    if (s3_spec) begin
      res_c   = s3_spec_res;
      flags_c = s3_spec_flags;
    end else if (s3_sum == '0) begin
      res_c   = {s3_zsign, {(W-1){1'b0}}};
      flags_c = 4'b0000;
    end else if (exp_out >= EXP_MAX) begin
      res_c   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end else begin
      res_c   = {s3_sign, exp_out[EXP_W-1:0],
                 mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0]};
      flags_c = {2'b00, tiny & inexact, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s3_valid;
      result    <= res_c;
      flags     <= flags_c;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: vector table, back-pressure stream and mid-flight reset.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] dina, dinb, result;
  logic [3:0]  flags;
  int          tests = 0;
  int          failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dina      (dina),
    .dinb      (dinb),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Single isolated operation; result must appear exactly 4 cycles after acceptance.
  task automatic run_vec(input int i);
    logic early;
    @(negedge clk);
    in_valid = 1'b1;
    dina     = vecs[i].a;
    dinb     = vecs[i].b;
    op       = vecs[i].op;
    #1;
    check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    early    = out_valid;
    repeat (2) begin
      @(negedge clk);
      early = early | out_valid;
    end
    @(negedge clk);
    check($sformatf("v%0d_early_valid", i), {31'b0, early}, 32'd0);
    check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
    check($sformatf("v%0d_result", i), result, vecs[i].res);
    check($sformatf("v%0d_flags", i), {28'b0, flags}, {28'b0, vecs[i].flg});
  endtask

  initial begin
    int sent, recv, seen;
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[2]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
    vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[5]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[10] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
    vecs[11] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001};
    vecs[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vecs[13] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b0;
    dina      = '0;
    dinb      = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'b0, flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Eight back-to-back operands with out_ready low in cycles 5..7.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        dina     = vecs[sent].a;
        dinb     = vecs[sent].b;
        op       = vecs[sent].op;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        check($sformatf("stall_in_ready_c%0d", cyc), {31'b0, in_ready}, 32'd0);
        check($sformatf("stall_out_valid_c%0d", cyc), {31'b0, out_valid}, 32'd1);
      end
      if (cyc == 4) check("stream_first_valid", {31'b0, out_valid}, 32'd1);
      if (out_valid) begin
        check($sformatf("stream_res%0d_c%0d", recv, cyc), result, vecs[recv].res);
        check($sformatf("stream_flg%0d_c%0d", recv, cyc), {28'b0, flags},
              {28'b0, vecs[recv].flg});
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", recv, 32'd8);

    // Reset with three operands in flight must flush them all.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      dina     = vecs[k + 1].a;
      dinb     = vecs[k + 1].b;
      op       = vecs[k + 1].op;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    check("flush_out_valid", seen, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    run_vec(10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
